// File: rtl/game_pkg.sv
// Shared types and defaults for the code-breaking game turn controller.
// Contents: FSM state enum, history-return enum, default game sizing constants.
package game_pkg;

  localparam int unsigned MaxTurnsDef  = 8;
  localparam int unsigned NumPegsDef   = 4;
  localparam int unsigned FbTimeoutDef = 16;
  localparam int unsigned TurnWDef     = $clog2(MaxTurnsDef + 1);

  typedef enum logic [2:0] {
    StClear,
    StGuess,
    StWaitFb,
    StHist,
    StWin,
    StLose
  } state_e;

  // Where the history view returns to when it is closed.
  typedef enum logic [1:0] {
    RetGuess,
    RetWin,
    RetLose
  } ret_e;

endpackage

// File: rtl/edge_detect.sv
// Per-bit rising-edge one-shot for debounced button levels.
// Ports: clk, reset_n (async, active-low), level (button levels), rise (one-cycle edge pulses).
module edge_detect #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] prev_q;

  // Resetting to all-ones makes every button look already pressed, so a button held
  // through reset produces no edge; the first clock after reset loads the real levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= '1;
    end else begin
      prev_q <= level;
    end
  end

  assign rise = level & ~prev_q;

endmodule

// File: rtl/game_sequencer.sv
// Turn controller for the code-breaking game: clears the guess history at game start,
// strobes one history store per committed guess, requests scoring and decides win/lose.
// Ports:
//   clk, reset_n                         clock, async active-low reset
//   btn_select, btn_mode, btn_new_game   debounced button levels (rising edge acts)
//   fb_valid, fb_exact                   feedback result pulse and exact-match count
//   mode, hist_clear, hist_store         history block controls
//   turn, last_turn                      guesses committed, final-guess indicator
//   fb_req                               level, high while awaiting feedback
//   win, lose, fb_error                  sticky status until a new game
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned MAX_TURNS  = MaxTurnsDef,
  parameter int unsigned NUM_PEGS   = NumPegsDef,
  parameter int unsigned FB_TIMEOUT = FbTimeoutDef
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           btn_select,
  input  logic                           btn_mode,
  input  logic                           btn_new_game,
  input  logic                           fb_valid,
  input  logic [2:0]                     fb_exact,
  output logic                           mode,
  output logic                           hist_clear,
  output logic                           hist_store,
  output logic [$clog2(MAX_TURNS+1)-1:0] turn,
  output logic                           last_turn,
  output logic                           fb_req,
  output logic                           win,
  output logic                           lose,
  output logic                           fb_error
);

  localparam int unsigned TurnW = $clog2(MAX_TURNS + 1);
  localparam int unsigned CntW  = $clog2(FB_TIMEOUT + 1);

  localparam logic [TurnW-1:0] TurnMax  = TurnW'(MAX_TURNS);
  localparam logic [TurnW-1:0] TurnLast = TurnW'(MAX_TURNS - 1);
  localparam logic [CntW-1:0]  CntLast  = CntW'(FB_TIMEOUT - 1);
  localparam logic [2:0]       ExactWin = 3'(NUM_PEGS);

  logic [2:0] btn_level, btn_rise;
  logic       select_rise, mode_rise, new_game_rise;

  assign btn_level = {btn_new_game, btn_mode, btn_select};

  edge_detect #(
    .WIDTH(3)
  ) u_edge_detect (
    .clk    (clk),
    .reset_n(reset_n),
    .level  (btn_level),
    .rise   (btn_rise)
  );

  assign select_rise   = btn_rise[0];
  assign mode_rise     = btn_rise[1];
  assign new_game_rise = btn_rise[2];

  state_e           state_q;
  ret_e             ret_q;
  logic [TurnW-1:0] turn_q;
  logic [CntW-1:0]  cnt_q;
  logic             hist_store_q, win_q, lose_q, fb_error_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StClear;
      ret_q        <= RetGuess;
      turn_q       <= '0;
      cnt_q        <= '0;
      hist_store_q <= 1'b0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
      fb_error_q   <= 1'b0;
    end else begin
      hist_store_q <= 1'b0;
      if (new_game_rise) begin
        // Clear status on entry so the CLEAR cycle already shows a fresh game.
        state_q    <= StClear;
        turn_q     <= '0;
        win_q      <= 1'b0;
        lose_q     <= 1'b0;
        fb_error_q <= 1'b0;
      end else begin
        unique case (state_q)
          StClear: begin
            turn_q     <= '0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
            fb_error_q <= 1'b0;
            state_q    <= StGuess;
          end
          StGuess: begin
            // Select beats mode; a simultaneous mode edge is dropped.
            if (select_rise && (turn_q < TurnMax)) begin
              hist_store_q <= 1'b1;
              turn_q       <= turn_q + TurnW'(1);
              cnt_q        <= '0;
              state_q      <= StWaitFb;
            end else if (mode_rise && (turn_q != '0)) begin
              ret_q   <= RetGuess;
              state_q <= StHist;
            end
          end
          StWaitFb: begin
            if (fb_valid) begin
              if (fb_exact == ExactWin) begin
                win_q   <= 1'b1;
                state_q <= StWin;
              end else if (turn_q == TurnMax) begin
                lose_q  <= 1'b1;
                state_q <= StLose;
              end else begin
                state_q <= StGuess;
              end
            end else if (cnt_q == CntLast) begin
              fb_error_q <= 1'b1;
              state_q    <= StGuess;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          StHist: begin
            if (mode_rise) begin
              unique case (ret_q)
                RetWin:  state_q <= StWin;
                RetLose: state_q <= StLose;
                default: state_q <= StGuess;
              endcase
            end
          end
          StWin: begin
            if (mode_rise) begin
              ret_q   <= RetWin;
              state_q <= StHist;
            end
          end
          StLose: begin
            if (mode_rise) begin
              ret_q   <= RetLose;
              state_q <= StHist;
            end
          end
          default: state_q <= StClear;
        endcase
      end
    end
  end

  // Gated by reset_n so the wipe strobe stays low while reset is held.
  assign hist_clear = reset_n && (state_q == StClear);
  assign mode       = (state_q == StHist);
  assign fb_req     = (state_q == StWaitFb);
  assign last_turn  = (state_q == StGuess) && (turn_q == TurnLast);
  assign hist_store = hist_store_q;
  assign turn       = turn_q;
  assign win        = win_q;
  assign lose       = lose_q;
  assign fb_error   = fb_error_q;

endmodule

// File: tb/tb_game_sequencer.sv
module tb_game_sequencer;

  localparam int MaxT = 8;
  localparam int Pegs = 4;
  localparam int Tmo  = 16;
  localparam int TW   = $clog2(MaxT + 1);

  localparam int PClear = 0;
  localparam int PPlay  = 1;
  localparam int PWait  = 2;
  localparam int PView  = 3;
  localparam int PWon   = 4;
  localparam int PLost  = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          btn_select = 1'b0, btn_mode = 1'b0, btn_new_game = 1'b0, fb_valid = 1'b0;
  logic [2:0]    fb_exact = 3'd0;
  logic          mode, hist_clear, hist_store, last_turn, fb_req, win, lose, fb_error;
  logic [TW-1:0] turn;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  game_sequencer #(
    .MAX_TURNS (MaxT),
    .NUM_PEGS  (Pegs),
    .FB_TIMEOUT(Tmo)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_select  (btn_select),
    .btn_mode    (btn_mode),
    .btn_new_game(btn_new_game),
    .fb_valid    (fb_valid),
    .fb_exact    (fb_exact),
    .mode        (mode),
    .hist_clear  (hist_clear),
    .hist_store  (hist_store),
    .turn        (turn),
    .last_turn   (last_turn),
    .fb_req      (fb_req),
    .win         (win),
    .lose        (lose),
    .fb_error    (fb_error)
  );

  // Reference model: game phase, guesses used, cycles waited, sticky flags.
  int m_phase, m_back, m_turn, m_waited;
  bit m_win, m_lose, m_err, m_store, m_in_reset;
  bit p_sel, p_mode, p_ng;

  function automatic logic [TW+7:0] obs_vec();
    return {mode, hist_clear, hist_store, last_turn, fb_req, win, lose, fb_error, turn};
  endfunction

  function automatic logic [TW+7:0] exp_vec();
    if (m_in_reset) return '0;
    return {m_phase == PView, m_phase == PClear, m_store,
            (m_phase == PPlay) && (m_turn == MaxT - 1), m_phase == PWait,
            m_win, m_lose, m_err, TW'(m_turn)};
  endfunction

  task automatic model_reset();
    m_in_reset = 1; m_phase = PClear; m_back = PPlay; m_turn = 0; m_waited = 0;
    m_win = 0; m_lose = 0; m_err = 0; m_store = 0;
    p_sel = btn_select; p_mode = btn_mode; p_ng = btn_new_game;
  endtask

  task automatic model_release();
    m_in_reset = 0;
    p_sel = btn_select; p_mode = btn_mode; p_ng = btn_new_game;
  endtask

  task automatic model_advance(input bit sel, input bit md, input bit ng, input bit fv,
                               input bit [2:0] fe);
    bit e_sel, e_md, e_ng;
    e_sel = sel && !p_sel;
    e_md  = md && !p_mode;
    e_ng  = ng && !p_ng;
    p_sel = sel; p_mode = md; p_ng = ng;
    m_store = 0;
    if (e_ng) begin
      m_phase = PClear; m_turn = 0; m_win = 0; m_lose = 0; m_err = 0;
    end else begin
      case (m_phase)
        PClear: m_phase = PPlay;
        PPlay: begin
          if (e_sel && m_turn < MaxT) begin
            m_store = 1; m_turn++; m_waited = 0; m_phase = PWait;
          end else if (e_md && m_turn > 0) begin
            m_back = PPlay; m_phase = PView;
          end
        end
        PWait: begin
          if (fv) begin
            if (int'(fe) == Pegs) begin m_win = 1; m_phase = PWon; end
            else if (m_turn == MaxT) begin m_lose = 1; m_phase = PLost; end
            else m_phase = PPlay;
          end else begin
            m_waited++;
            if (m_waited >= Tmo) begin m_err = 1; m_phase = PPlay; end
          end
        end
        PView: if (e_md) m_phase = m_back;
        PWon, PLost: if (e_md) begin m_back = m_phase; m_phase = PView; end
        default: ;
      endcase
    end
  endtask

  // Drive one cycle of inputs, let the clock edge pass, advance the model.
  task automatic tick(input bit sel, input bit md, input bit ng, input bit fv,
                      input bit [2:0] fe);
    btn_select = sel; btn_mode = md; btn_new_game = ng; fb_valid = fv; fb_exact = fe;
    @(posedge clk);
    model_advance(sel, md, ng, fv, fe);
    #1;
  endtask

  task automatic new_game();
    tick(0, 0, 1, 0, 3'd0);
    tick(0, 0, 0, 0, 3'd0);
  endtask

  task automatic test_reset();
    reset_n = 0; btn_select = 1; btn_mode = 0; btn_new_game = 0; fb_valid = 0; fb_exact = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (obs_vec() !== '0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", obs_vec());
    end
    reset_n = 1; model_release(); #1;
    total++;
    if (hist_clear !== 1'b1) begin
      bad++; $display("FAIL clear_first_cycle: got %b want 1", hist_clear);
    end
    tick(1, 0, 0, 0, 3'd0);
    total++;
    if ({hist_clear, mode, fb_req, turn} !== '0) begin
      bad++; $display("FAIL after_clear: got %b%b%b turn=%0d want 000 turn=0",
                      hist_clear, mode, fb_req, turn);
    end
    tick(1, 0, 0, 0, 3'd0);
    total++;
    if (hist_store !== 1'b0 || fb_req !== 1'b0) begin
      bad++; $display("FAIL held_through_reset: store=%b req=%b want 0 0", hist_store, fb_req);
    end
    tick(0, 0, 0, 0, 3'd0);
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_model: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_single_guess();
    int req_cycles = 0;
    int stores = 0;
    tick(1, 0, 0, 0, 3'd0);
    total++;
    if (hist_store !== 1'b1 || turn !== TW'(1)) begin
      bad++; $display("FAIL guess_store: store=%b turn=%0d want 1 1", hist_store, turn);
    end
    for (int c = 0; c < 3; c++) begin
      req_cycles += int'(fb_req);
      stores += int'(hist_store);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL guess_wait c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      tick(0, 0, 0, c == 2, 3'd2);
    end
    total++;
    if (req_cycles != 3 || stores != 1 || fb_req !== 1'b0 || win !== 1'b0) begin
      bad++; $display("FAIL guess_scored: req=%0d stores=%0d fb_req=%b win=%b want 3 1 0 0",
                      req_cycles, stores, fb_req, win);
    end
  endtask

  task automatic test_lose();
    new_game();
    for (int g = 0; g < MaxT; g++) begin
      total++;
      if (last_turn !== (g == MaxT - 1) || turn !== TW'(g)) begin
        bad++; $display("FAIL last_turn g%0d: got %b turn=%0d want %b", g, last_turn, turn,
                        g == MaxT - 1);
      end
      tick(1, 0, 0, 0, 3'd0);
      tick(0, 0, 0, 1, 3'd1);
    end
    total++;
    if (lose !== 1'b1 || win !== 1'b0 || turn !== TW'(MaxT)) begin
      bad++; $display("FAIL lose: lose=%b win=%b turn=%0d want 1 0 %0d", lose, win, turn, MaxT);
    end
    for (int k = 0; k < 3; k++) begin
      tick(1, 0, 0, 0, 3'd0);
      total++;
      if (hist_store !== 1'b0 || turn !== TW'(MaxT) || obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL select_after_lose: got %h want %h", obs_vec(), exp_vec());
      end
      tick(0, 0, 0, 0, 3'd0);
    end
  endtask

  task automatic test_win();
    bit [2:0] scores [3] = '{3'd0, 3'd3, 3'd4};
    new_game();
    for (int g = 0; g < 3; g++) begin
      tick(1, 0, 0, 0, 3'd0);
      tick(0, 0, 0, 1, scores[g]);
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL win_guess g%0d: got %h want %h", g, obs_vec(), exp_vec());
      end
    end
    total++;
    if (win !== 1'b1 || lose !== 1'b0 || turn !== TW'(3)) begin
      bad++; $display("FAIL win: win=%b lose=%b turn=%0d want 1 0 3", win, lose, turn);
    end
    tick(0, 1, 0, 0, 3'd0);
    total++;
    if (mode !== 1'b1 || win !== 1'b1) begin
      bad++; $display("FAIL win_hist: mode=%b win=%b want 1 1", mode, win);
    end
    tick(1, 0, 0, 1, 3'd0);
    tick(0, 1, 0, 0, 3'd0);
    total++;
    if (mode !== 1'b0 || win !== 1'b1 || hist_store !== 1'b0) begin
      bad++; $display("FAIL win_return: mode=%b win=%b store=%b want 0 1 0", mode, win,
                      hist_store);
    end
  endtask

  task automatic test_timeout();
    new_game();
    tick(1, 0, 0, 0, 3'd0);
    for (int c = 0; c < Tmo - 1; c++) tick(0, 0, 0, 0, 3'd0);
    total++;
    if (fb_error !== 1'b0 || fb_req !== 1'b1) begin
      bad++; $display("FAIL timeout_early: err=%b req=%b want 0 1", fb_error, fb_req);
    end
    tick(0, 0, 0, 0, 3'd0);
    total++;
    if (fb_error !== 1'b1 || fb_req !== 1'b0 || turn !== TW'(1) || last_turn !== 1'b0) begin
      bad++; $display("FAIL timeout: err=%b req=%b turn=%0d want 1 0 1", fb_error, fb_req, turn);
    end
    tick(0, 0, 1, 0, 3'd0);
    total++;
    if (hist_clear !== 1'b1 || turn !== '0 || fb_error !== 1'b0) begin
      bad++; $display("FAIL timeout_newgame: clr=%b turn=%0d err=%b want 1 0 0", hist_clear,
                      turn, fb_error);
    end
    tick(0, 0, 0, 0, 3'd0);
    total++;
    if (hist_clear !== 1'b0) begin
      bad++; $display("FAIL clear_one_cycle: got %b want 0", hist_clear);
    end
  endtask

  task automatic test_simultaneous();
    int stores = 0;
    new_game();
    tick(0, 1, 0, 0, 3'd0);
    total++;
    if (mode !== 1'b0) begin
      bad++; $display("FAIL mode_turn0: got %b want 0", mode);
    end
    tick(0, 0, 0, 0, 3'd0);
    tick(1, 1, 0, 0, 3'd0);
    total++;
    if (hist_store !== 1'b1 || mode !== 1'b0) begin
      bad++; $display("FAIL sel_beats_mode: store=%b mode=%b want 1 0", hist_store, mode);
    end
    tick(0, 0, 0, 1, 3'd5);
    total++;
    if (mode !== 1'b0 || win !== 1'b0 || fb_req !== 1'b0) begin
      bad++; $display("FAIL exact5_nonwin: mode=%b win=%b req=%b want 0 0 0", mode, win, fb_req);
    end
    for (int c = 0; c < 20; c++) begin
      tick(1, 0, 0, 0, 3'd0);
      stores += int'(hist_store);
    end
    total++;
    if (stores != 1) begin
      bad++; $display("FAIL held_select: got %0d stores want 1", stores);
    end
    tick(0, 0, 0, 0, 3'd0);
  endtask

  task automatic test_reset_mid_wait();
    new_game();
    tick(1, 0, 0, 0, 3'd0);
    tick(0, 0, 0, 0, 3'd0);
    #2;
    reset_n = 0; model_reset(); #1;
    total++;
    if (fb_req !== 1'b0 || turn !== '0 || obs_vec() !== '0) begin
      bad++; $display("FAIL async_abort: got %h want 0", obs_vec());
    end
    @(posedge clk); #1;
    reset_n = 1; model_release(); #1;
    total++;
    if (hist_clear !== 1'b1 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL abort_release: got %h want %h", obs_vec(), exp_vec());
    end
    tick(0, 0, 0, 0, 3'd0);
  endtask

  task automatic test_random();
    bit sel = 0, md = 0, ng = 0;
    for (int c = 0; c < 800; c++) begin
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL random c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if ($urandom_range(0, 2) == 0) sel = ~sel;
      if ($urandom_range(0, 5) == 0) md = ~md;
      ng = ($urandom_range(0, 79) == 0);
      tick(sel, md, ng, $urandom_range(0, 4) == 0, 3'($urandom_range(0, 7)));
    end
  endtask

  initial begin
    test_reset();
    test_single_guess();
    test_lose();
    test_win();
    test_timeout();
    test_simultaneous();
    test_reset_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
